// File: rtl/m_pcpi_master.sv
// PCPI initiator: issues one core instruction to the co-processor, returns result or illegal flag.
// Latency: >=1 cycle accept->pcpi_valid, response registered; resp held until resp_ready. Optional: M_PCPI_FILTER_EN.
module m_pcpi_master #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_instr,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_wr,
    output logic [31:0] resp_data,
    output logic        resp_illegal,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_instruction,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_busy,
    input  logic        pcpi_ready
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic        pcpi_valid_nxt;
    logic [31:0] pcpi_instruction_nxt, pcpi_rs1_nxt, pcpi_rs2_nxt;
    logic        resp_valid_nxt, resp_wr_nxt, resp_illegal_nxt;
    logic [31:0] resp_data_nxt;
    logic        issue_ok;

`ifdef M_PCPI_FILTER_EN
    // Only OP-opcode instructions with funct7 = MULDIV are offered to the co-processor.
    assign issue_ok = (req_instr[6:0] == 7'b0110011) && (req_instr[31:25] == 7'b0000001);
`else
    assign issue_ok = 1'b1;
`endif

    assign req_ready = (state == S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            cnt              <= '0;
            pcpi_valid       <= 1'b0;
            pcpi_instruction <= '0;
            pcpi_rs1         <= '0;
            pcpi_rs2         <= '0;
            resp_valid       <= 1'b0;
            resp_wr          <= 1'b0;
            resp_data        <= '0;
            resp_illegal     <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            pcpi_valid       <= pcpi_valid_nxt;
            pcpi_instruction <= pcpi_instruction_nxt;
            pcpi_rs1         <= pcpi_rs1_nxt;
            pcpi_rs2         <= pcpi_rs2_nxt;
            resp_valid       <= resp_valid_nxt;
            resp_wr          <= resp_wr_nxt;
            resp_data        <= resp_data_nxt;
            resp_illegal     <= resp_illegal_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_valid) state_nxt = issue_ok ? S_ISSUE : S_RESP;
            S_ISSUE: begin
                if (pcpi_ready)           state_nxt = S_RESP;
                else if (pcpi_busy)       state_nxt = S_WAIT;
                else if (cnt == CNT_LAST) state_nxt = S_RESP;
            end
            S_WAIT:  if (pcpi_ready) state_nxt = S_RESP;
            S_RESP:  if (resp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt              = cnt;
        pcpi_valid_nxt       = pcpi_valid;
        pcpi_instruction_nxt = pcpi_instruction;
        pcpi_rs1_nxt         = pcpi_rs1;
        pcpi_rs2_nxt         = pcpi_rs2;
        resp_valid_nxt       = resp_valid;
        resp_wr_nxt          = resp_wr;
        resp_data_nxt        = resp_data;
        resp_illegal_nxt     = resp_illegal;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    pcpi_instruction_nxt = req_instr;
                    pcpi_rs1_nxt         = req_rs1;
                    pcpi_rs2_nxt         = req_rs2;
                    cnt_nxt              = '0;
                    if (issue_ok) begin
                        pcpi_valid_nxt = 1'b1;
                    end else begin
                        resp_valid_nxt   = 1'b1;
                        resp_illegal_nxt = 1'b1;
                        resp_wr_nxt      = 1'b0;
                        resp_data_nxt    = '0;
                    end
                end
            end
            S_ISSUE: begin
                // A result arriving on the expiry cycle still wins over the timeout.
                if (pcpi_ready) begin
                    pcpi_valid_nxt   = 1'b0;
                    resp_valid_nxt   = 1'b1;
                    resp_wr_nxt      = pcpi_wr;
                    resp_data_nxt    = pcpi_wr ? pcpi_rd : 32'd0;
                    resp_illegal_nxt = 1'b0;
                end else if (pcpi_busy) begin
                    cnt_nxt = cnt;
                end else if (cnt == CNT_LAST) begin
                    pcpi_valid_nxt   = 1'b0;
                    resp_valid_nxt   = 1'b1;
                    resp_wr_nxt      = 1'b0;
                    resp_data_nxt    = '0;
                    resp_illegal_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (pcpi_ready) begin
                    pcpi_valid_nxt   = 1'b0;
                    resp_valid_nxt   = 1'b1;
                    resp_wr_nxt      = pcpi_wr;
                    resp_data_nxt    = pcpi_wr ? pcpi_rd : 32'd0;
                    resp_illegal_nxt = 1'b0;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_nxt   = 1'b0;
                    resp_wr_nxt      = 1'b0;
                    resp_data_nxt    = '0;
                    resp_illegal_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_m_pcpi_master.sv
// Bench for m_pcpi_master: per-scenario tasks, expected responses queued at stimulus time.
module tb_m_pcpi_master;

    localparam logic [31:0] I_MUL = 32'h02B50533;
    localparam logic [31:0] I_ADD = 32'h00B50533;
`ifdef M_PCPI_FILTER_EN
    localparam logic [31:0] I_TMO = I_MUL;
`else
    localparam logic [31:0] I_TMO = I_ADD;
`endif

    typedef struct packed {
        logic        wr;
        logic [31:0] data;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [31:0] req_instr, req_rs1, req_rs2;
    logic        resp_valid, resp_ready, resp_wr, resp_illegal;
    logic [31:0] resp_data;
    logic        pcpi_valid;
    logic [31:0] pcpi_instruction, pcpi_rs1, pcpi_rs2;
    logic        pcpi_wr, pcpi_busy, pcpi_ready;
    logic [31:0] pcpi_rd;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    m_pcpi_master #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_instr(req_instr), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_wr(resp_wr),
        .resp_data(resp_data), .resp_illegal(resp_illegal),
        .pcpi_valid(pcpi_valid), .pcpi_instruction(pcpi_instruction),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
        .pcpi_busy(pcpi_busy), .pcpi_ready(pcpi_ready)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
        int w = 0;
        while (!req_ready && w < 50) begin
            tick;
            w++;
        end
        req_valid = 1'b1;
        req_instr = i;
        req_rs1   = r1;
        req_rs2   = r2;
        tick;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output bit seen);
        int w = 0;
        while (!resp_valid && w < 100) begin
            tick;
            w++;
        end
        seen = resp_valid;
    endtask

    task automatic release_resp;
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_valid = 0; req_instr = 0; req_rs1 = 0; req_rs2 = 0;
        resp_ready = 0; pcpi_wr = 0; pcpi_rd = 0; pcpi_busy = 0; pcpi_ready = 0;
        tick; tick;
        n_cmp++;
        if ({pcpi_valid, resp_valid, resp_wr, resp_illegal, resp_data, pcpi_instruction, pcpi_rs1, pcpi_rs2} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got pv=%b rv=%b data=%h instr=%h want all zero",
                     pcpi_valid, resp_valid, resp_data, pcpi_instruction);
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_req_ready: got %b want 1", req_ready);
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_mul;
        exp_t e;
        bit   seen;
        issue(I_MUL, 32'd6, 32'd7);
        n_cmp++;
        if ({pcpi_valid, pcpi_instruction, pcpi_rs1, pcpi_rs2} !== {1'b1, I_MUL, 32'd6, 32'd7}) begin
            n_err++;
            $display("FAIL mul_issue: got pv=%b instr=%h rs1=%0d rs2=%0d want 1 %h 6 7",
                     pcpi_valid, pcpi_instruction, pcpi_rs1, pcpi_rs2, I_MUL);
        end
        sb.push_back('{wr: 1'b1, data: 32'd42, illegal: 1'b0});
        pcpi_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            n_cmp++;
            if ({pcpi_valid, resp_valid, pcpi_rs1} !== {1'b1, 1'b0, 32'd6}) begin
                n_err++;
                $display("FAIL mul_wait%0d: got pv=%b rv=%b rs1=%0d want 1 0 6", k, pcpi_valid, resp_valid, pcpi_rs1);
            end
        end
        pcpi_busy = 1'b0; pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'd42;
        tick;
        pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = 32'd0;
        n_cmp++;
        if (pcpi_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mul_pv_drop: got %b want 0", pcpi_valid);
        end
        wait_resp(seen);
        e = sb.pop_front();
        n_cmp++;
        if (!seen || {resp_wr, resp_data, resp_illegal} !== {e.wr, e.data, e.illegal}) begin
            n_err++;
            $display("FAIL mul_resp: got v=%b wr=%b data=%h ill=%b want 1 %b %h %b",
                     resp_valid, resp_wr, resp_data, resp_illegal, e.wr, e.data, e.illegal);
        end
        release_resp;
        n_cmp++;
        if ({resp_valid, resp_wr, resp_data, resp_illegal, req_ready} !== {35'd0, 1'b1}) begin
            n_err++;
            $display("FAIL mul_release: got rv=%b wr=%b data=%h ill=%b rr=%b want 0 0 0 0 1",
                     resp_valid, resp_wr, resp_data, resp_illegal, req_ready);
        end
    endtask

    task automatic test_timeout;
        exp_t e;
        bit   seen;
        int   hi = 0;
        issue(I_TMO, 32'd1, 32'd2);
        sb.push_back('{wr: 1'b0, data: 32'd0, illegal: 1'b1});
        while (pcpi_valid && hi < 100) begin
            hi++;
            tick;
        end
        n_cmp++;
        if (hi != 16) begin
            n_err++;
            $display("FAIL timeout_len: pcpi_valid high %0d cycles want 16", hi);
        end
        wait_resp(seen);
        e = sb.pop_front();
        n_cmp++;
        if (!seen || {resp_wr, resp_data, resp_illegal} !== {e.wr, e.data, e.illegal}) begin
            n_err++;
            $display("FAIL timeout_resp: got v=%b wr=%b data=%h ill=%b want 1 %b %h %b",
                     resp_valid, resp_wr, resp_data, resp_illegal, e.wr, e.data, e.illegal);
        end
        release_resp;
    endtask

    task automatic test_race;
        exp_t e;
        bit   seen;
        issue(I_MUL, 32'd3, 32'd4);
        for (int k = 0; k < 15; k++) tick;
        n_cmp++;
        if (pcpi_valid !== 1'b1) begin
            n_err++;
            $display("FAIL race_pv16: got %b want 1", pcpi_valid);
        end
        sb.push_back('{wr: 1'b1, data: 32'h1234, illegal: 1'b0});
        pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'h1234;
        tick;
        pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = 32'd0;
        wait_resp(seen);
        e = sb.pop_front();
        n_cmp++;
        if (!seen || {resp_wr, resp_data, resp_illegal} !== {e.wr, e.data, e.illegal}) begin
            n_err++;
            $display("FAIL race_resp: got v=%b wr=%b data=%h ill=%b want 1 %b %h %b",
                     resp_valid, resp_wr, resp_data, resp_illegal, e.wr, e.data, e.illegal);
        end
        release_resp;
    endtask

    task automatic test_no_write;
        exp_t e;
        issue(I_MUL, 32'd9, 32'd9);
        sb.push_back('{wr: 1'b0, data: 32'd0, illegal: 1'b0});
        pcpi_ready = 1'b1; pcpi_wr = 1'b0; pcpi_rd = 32'hDEAD_BEEF;
        tick;
        pcpi_ready = 1'b0; pcpi_rd = 32'd0;
        e = sb.pop_front();
        n_cmp++;
        if ({resp_valid, resp_wr, resp_data, resp_illegal} !== {1'b1, e.wr, e.data, e.illegal}) begin
            n_err++;
            $display("FAIL nowr_resp: got v=%b wr=%b data=%h ill=%b want 1 %b %h %b",
                     resp_valid, resp_wr, resp_data, resp_illegal, e.wr, e.data, e.illegal);
        end
        release_resp;
    endtask

    task automatic test_long_wait;
        exp_t e;
        bit   seen;
        int   drops = 0;
        issue(I_MUL, 32'd100, 32'd200);
        sb.push_back('{wr: 1'b1, data: 32'hCAFE_0001, illegal: 1'b0});
        for (int k = 0; k < 28; k++) begin
            pcpi_busy = (k < 25);
            tick;
            if (pcpi_valid !== 1'b1 || resp_valid !== 1'b0) drops++;
        end
        n_cmp++;
        if (drops != 0) begin
            n_err++;
            $display("FAIL long_wait_hold: pcpi_valid/resp_valid wrong in %0d cycles want 0", drops);
        end
        pcpi_busy = 1'b0; pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'hCAFE_0001;
        tick;
        pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = 32'd0;
        wait_resp(seen);
        e = sb.pop_front();
        n_cmp++;
        if (!seen || {resp_wr, resp_data, resp_illegal} !== {e.wr, e.data, e.illegal}) begin
            n_err++;
            $display("FAIL long_wait_resp: got v=%b wr=%b data=%h ill=%b want 1 %b %h %b",
                     resp_valid, resp_wr, resp_data, resp_illegal, e.wr, e.data, e.illegal);
        end
        release_resp;
    endtask

    task automatic test_backpressure;
        exp_t e;
        bit   seen;
        int   bad = 0;
        issue(I_MUL, 32'd3, 32'd5);
        sb.push_back('{wr: 1'b1, data: 32'h0000_ABCD, illegal: 1'b0});
        pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'h0000_ABCD;
        tick;
        pcpi_ready = 1'b0; pcpi_rd = 32'd0;
        req_valid = 1'b1; req_instr = I_MUL; req_rs1 = 32'd11; req_rs2 = 32'd12;
        for (int k = 0; k < 5; k++) begin
            if ({resp_valid, resp_wr, resp_data, resp_illegal} !== {1'b1, sb[0].wr, sb[0].data, sb[0].illegal}
                || req_ready !== 1'b0 || pcpi_valid !== 1'b0) bad++;
            pcpi_ready = (k == 2);
            pcpi_rd    = (k == 2) ? 32'hFFFF_FFFF : 32'd0;
            tick;
        end
        pcpi_ready = 1'b0; pcpi_rd = 32'd0;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL bp_hold: response/handshake wrong in %0d of 5 stalled cycles want 0", bad);
        end
        wait_resp(seen);
        e = sb.pop_front();
        n_cmp++;
        if (!seen || {resp_wr, resp_data, resp_illegal} !== {e.wr, e.data, e.illegal}) begin
            n_err++;
            $display("FAIL bp_resp: got v=%b wr=%b data=%h ill=%b want 1 %b %h %b",
                     resp_valid, resp_wr, resp_data, resp_illegal, e.wr, e.data, e.illegal);
        end
        release_resp;
        n_cmp++;
        if ({resp_valid, req_ready, pcpi_valid} !== 3'b010) begin
            n_err++;
            $display("FAIL bp_turnaround: got rv=%b rr=%b pv=%b want 0 1 0", resp_valid, req_ready, pcpi_valid);
        end
        tick;
        req_valid = 1'b0;
        n_cmp++;
        if ({pcpi_valid, pcpi_rs1, pcpi_rs2} !== {1'b1, 32'd11, 32'd12}) begin
            n_err++;
            $display("FAIL bp_second_issue: got pv=%b rs1=%0d rs2=%0d want 1 11 12", pcpi_valid, pcpi_rs1, pcpi_rs2);
        end
        sb.push_back('{wr: 1'b0, data: 32'd0, illegal: 1'b0});
        pcpi_ready = 1'b1; pcpi_wr = 1'b0; pcpi_rd = 32'h77;
        tick;
        pcpi_ready = 1'b0; pcpi_rd = 32'd0;
        wait_resp(seen);
        e = sb.pop_front();
        n_cmp++;
        if (!seen || {resp_wr, resp_data, resp_illegal} !== {e.wr, e.data, e.illegal}) begin
            n_err++;
            $display("FAIL bp_second_resp: got v=%b wr=%b data=%h ill=%b want 1 %b %h %b",
                     resp_valid, resp_wr, resp_data, resp_illegal, e.wr, e.data, e.illegal);
        end
        release_resp;
    endtask

    task automatic test_reset_wait;
        issue(I_MUL, 32'd8, 32'd9);
        pcpi_busy = 1'b1;
        tick; tick;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({pcpi_valid, resp_valid, pcpi_instruction} !== 34'd0) begin
            n_err++;
            $display("FAIL rst_async: got pv=%b rv=%b instr=%h want 0 0 0", pcpi_valid, resp_valid, pcpi_instruction);
        end
        #1;
        reset = 1'b0;
        tick;
        pcpi_busy = 1'b0; pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'h55;
        tick;
        pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = 32'd0;
        tick;
        n_cmp++;
        if ({resp_valid, pcpi_valid, req_ready, resp_data} !== {3'b001, 32'd0}) begin
            n_err++;
            $display("FAIL rst_ignore_ready: got rv=%b pv=%b rr=%b data=%h want 0 0 1 0",
                     resp_valid, pcpi_valid, req_ready, resp_data);
        end
    endtask

`ifdef M_PCPI_FILTER_EN
    task automatic test_filter;
        exp_t e;
        issue(I_ADD, 32'd1, 32'd1);
        sb.push_back('{wr: 1'b0, data: 32'd0, illegal: 1'b1});
        e = sb.pop_front();
        n_cmp++;
        if ({pcpi_valid, resp_valid, resp_wr, resp_data, resp_illegal} !== {2'b01, e.wr, e.data, e.illegal}) begin
            n_err++;
            $display("FAIL filter_add: got pv=%b rv=%b wr=%b data=%h ill=%b want 0 1 %b %h %b",
                     pcpi_valid, resp_valid, resp_wr, resp_data, resp_illegal, e.wr, e.data, e.illegal);
        end
        release_resp;
    endtask
`endif

    initial begin
        test_reset;
        test_mul;
        test_timeout;
        test_race;
        test_no_write;
        test_long_wait;
        test_backpressure;
        test_reset_wait;
`ifdef M_PCPI_FILTER_EN
        test_filter;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
